// File: rtl/ffo_pkg.sv
// Shared types and helpers for the find-first-one / normalise pipeline.
package ffo_pkg;

  // Search direction carried with each transaction.
  typedef enum logic {
    FFO_MSB = 1'b0,
    FFO_LSB = 1'b1
  } ffo_mode_t;

  // Widest legal operand is 64 bits; the zero count then needs 7 bits.
  localparam int FFO_MAX_WIDTH = 64;
  localparam int FFO_CNT_MAX_W = 7;

  // Count reported for an all-zero operand: every bit was skipped.
  function automatic logic [FFO_CNT_MAX_W-1:0] ffo_zero_count(input int unsigned width);
    return FFO_CNT_MAX_W'(width);
  endfunction

endpackage

// File: rtl/ffo_normalize_pipe_if.sv
// Input/output handshake bundle for ffo_normalize_pipe.
interface ffo_normalize_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData;
  logic             inMode;
  logic             outValid;
  logic             outReady;
  logic             outFound;
  logic [IDX_W-1:0] outIndex;
  logic [CNT_W-1:0] outCount;
  logic [WIDTH-1:0] outData;
  logic             outMode;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output inValid, inData, inMode, outReady,
    input  inReady, outValid, outFound, outIndex, outCount, outData, outMode
  );

  // The normalise unit itself.
  modport slave (
    input  inValid, inData, inMode, outReady,
    output inReady, outValid, outFound, outIndex, outCount, outData, outMode
  );
endinterface

// File: rtl/ffo_encode.sv
// Combinational find-first-one encoder built as a halving tree.
// The operand is zero-padded to a power of two; each tree node merges two
// halves, picking the upper half (MSB search) or the lower half (LSB search)
// when it holds a one. Padding bits are zero, so the index never points past
// WIDTH-1, and an all-zero operand yields index 0.
module ffo_encode
  import ffo_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  ffo_mode_t        i_mode,
  output logic             o_found,
  output logic [IDX_W-1:0] o_index
);

  localparam int P = 1 << IDX_W;

  logic [P-1:0]     w_pad;
  // Heap-ordered tree: node n has children 2n (low half) and 2n+1 (high half);
  // leaves P..2P-1 are the operand bits, node 1 is the root.
  logic [2*P-1:1]   w_f;
  logic [IDX_W-1:0] w_i [1:2*P-1];

  assign w_pad = P'(i_data);

  // Evaluate the tree level by level from the leaves up to the root.
  always_comb begin
    w_f = '0;
    for (int n = 1; n < 2 * P; n++) begin
      w_i[n] = '0;
    end
    for (int n = 0; n < P; n++) begin
      w_f[P + n] = w_pad[n];
    end
    for (int l = 1; l <= IDX_W; l++) begin
      for (int n = (P >> l); n < (P >> (l - 1)); n++) begin
        logic v_sel;
        if (i_mode == FFO_MSB) begin
          v_sel = w_f[2*n+1];
        end else begin
          v_sel = !w_f[2*n] && w_f[2*n+1];
        end
        w_f[n]      = w_f[2*n] | w_f[2*n+1];
        w_i[n]      = v_sel ? w_i[2*n+1] : w_i[2*n];
        w_i[n][l-1] = v_sel;
      end
    end
  end

  assign o_found = w_f[1];
  assign o_index = w_i[1];

endmodule

// File: rtl/ffo_normalize_pipe.sv
// Two-stage find-first-one and normalise pipeline with valid/ready flow control.
// Stage 1 registers the operand together with the encoder result; stage 2
// derives the zero count, barrel-shifts the operand and holds the result until
// the consumer takes it.
module ffo_normalize_pipe
  import ffo_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              resetN,
  ffo_normalize_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(ffo_zero_count(WIDTH));

  // Stage-1 payload: the operand plus what the encoder found in it.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    ffo_mode_t        mode;
    logic             found;
    logic [IDX_W-1:0] index;
  } s1_payload_t;

  logic        r_s1_valid;
  s1_payload_t r_s1;

  logic             r_out_valid;
  logic             r_out_found;
  logic [IDX_W-1:0] r_out_index;
  logic [CNT_W-1:0] r_out_count;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_mode;

  logic             w_s2_free;
  logic             w_s1_free;
  logic             w_in_xfer;
  logic             w_s2_load;
  ffo_mode_t        w_in_mode;
  logic             w_enc_found;
  logic [IDX_W-1:0] w_enc_index;
  logic [CNT_W-1:0] w_count;
  logic [WIDTH-1:0] w_norm;

  // Each stage may advance when the stage after it is empty or draining.
  assign w_s2_free = !r_out_valid || bus.outReady;
  assign w_s1_free = !r_s1_valid || w_s2_free;
  assign w_in_xfer = bus.inValid && w_s1_free;
  assign w_s2_load = r_s1_valid && w_s2_free;
  assign w_in_mode = ffo_mode_t'(bus.inMode);

  ffo_encode #(
    .WIDTH (WIDTH)
  ) u_encode (
    .i_data  (bus.inData),
    .i_mode  (w_in_mode),
    .o_found (w_enc_found),
    .o_index (w_enc_index)
  );

  // Stage 1: capture the operand and encoder result on an input transfer.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1.data  <= bus.inData;
      r_s1.mode  <= w_in_mode;
      r_s1.found <= w_enc_found;
      r_s1.index <= w_enc_index;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Zero count and normalising shift; counts stay within CNT_W so no wrap occurs.
  always_comb begin
    w_count = ZERO_CNT;
    w_norm  = '0;
    if (r_s1.found) begin
      if (r_s1.mode == FFO_LSB) begin
        w_count = CNT_W'(r_s1.index);
        w_norm  = r_s1.data >> w_count;
      end else begin
        w_count = CNT_W'(WIDTH - 1) - CNT_W'(r_s1.index);
        w_norm  = r_s1.data << w_count;
      end
    end
  end

  // Stage 2: load a new result, or drop valid once the consumer has taken it.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_out_valid <= 1'b0;
      r_out_found <= 1'b0;
      r_out_index <= '0;
      r_out_count <= '0;
      r_out_data  <= '0;
      r_out_mode  <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_out_found <= r_s1.found;
      r_out_index <= r_s1.index;
      r_out_count <= w_count;
      r_out_data  <= w_norm;
      r_out_mode  <= r_s1.mode;
    end else if (bus.outReady) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.inReady  = w_s1_free;
  assign bus.outValid = r_out_valid;
  assign bus.outFound = r_out_found;
  assign bus.outIndex = r_out_index;
  assign bus.outCount = r_out_count;
  assign bus.outData  = r_out_data;
  assign bus.outMode  = r_out_mode;

endmodule

// File: tb/tb_ffo_normalize_pipe.sv
// Self-checking bench: directed vectors and stall/reset sequences on a 32-bit
// unit, plus a randomized scoreboard run on a 25-bit unit.
module tb_ffo_normalize_pipe;
  import ffo_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  ffo_normalize_pipe_if #(.WIDTH(32)) bus32 ();
  ffo_normalize_pipe_if #(.WIDTH(25)) bus25 ();

  ffo_normalize_pipe #(.WIDTH(32)) dut32 (
    .clock  (clk),
    .resetN (resetN),
    .bus    (bus32)
  );

  ffo_normalize_pipe #(.WIDTH(25)) dut25 (
    .clock  (clk),
    .resetN (resetN),
    .bus    (bus25)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Directed vectors for the 32-bit unit.
  typedef struct {
    logic [31:0] data;
    logic        mode;
    logic        found;
    logic [4:0]  idx;
    logic [5:0]  cnt;
    logic [31:0] odata;
  } vec_t;
  vec_t vecs [8];

  // Result record used by the reference model and scoreboard.
  typedef struct packed {
    logic        found;
    logic [6:0]  idx;
    logic [6:0]  cnt;
    logic [63:0] data;
    logic        mode;
  } res_t;

  typedef struct {
    logic [63:0] data;
    logic        mode;
  } stim_t;

  // Reference: scan the bits directly and apply the normalising shift.
  function automatic res_t model(input logic [63:0] d, input logic m, input int w);
    res_t        r;
    int          pos;
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < w; i++) mask[i] = 1'b1;
    pos    = -1;
    r      = '0;
    r.mode = m;
    r.cnt  = ffo_zero_count(w);
    if (m == 1'b0) begin
      for (int i = 0; i < w; i++) begin
        if (d[i]) pos = i;
      end
    end else begin
      for (int i = w - 1; i >= 0; i--) begin
        if (d[i]) pos = i;
      end
    end
    if (pos >= 0) begin
      r.found = 1'b1;
      r.idx   = 7'(pos);
      if (m == 1'b0) begin
        r.cnt  = 7'(w - 1 - pos);
        r.data = (d << (w - 1 - pos)) & mask;
      end else begin
        r.cnt  = 7'(pos);
        r.data = d >> pos;
      end
    end
    return r;
  endfunction

  function automatic res_t cur25();
    res_t r;
    r.found = bus25.outFound;
    r.idx   = 7'(bus25.outIndex);
    r.cnt   = 7'(bus25.outCount);
    r.data  = 64'(bus25.outData);
    r.mode  = bus25.outMode;
    return r;
  endfunction

  stim_t       stim_q [$];
  res_t        exp_q  [$];
  logic [31:0] bp_items [4];

  initial begin
    res_t        act, held, e;
    logic        hold_prev;
    int          acc, idx, cyc, seen;
    logic [63:0] r;
    stim_t       s;

    vecs[0] = '{32'h0001_0000, 1'b0, 1'b1, 5'd16, 6'd15, 32'h8000_0000};
    vecs[1] = '{32'h0000_0A00, 1'b1, 1'b1, 5'd9,  6'd9,  32'h0000_0005};
    vecs[2] = '{32'h0000_0000, 1'b0, 1'b0, 5'd0,  6'd32, 32'h0000_0000};
    vecs[3] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0,  6'd32, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 5'd31, 6'd0,  32'hFFFF_FFFF};
    vecs[5] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 5'd0,  6'd0,  32'hFFFF_FFFF};
    vecs[6] = '{32'h0000_0001, 1'b0, 1'b1, 5'd0,  6'd31, 32'h8000_0000};
    vecs[7] = '{32'h8000_0000, 1'b1, 1'b1, 5'd31, 6'd31, 32'h0000_0001};
    bp_items[0] = 32'h1;
    bp_items[1] = 32'h2;
    bp_items[2] = 32'h4;
    bp_items[3] = 32'h8;

    resetN         = 1'b0;
    bus32.inValid  = 1'b0;
    bus32.inData   = '0;
    bus32.inMode   = 1'b0;
    bus32.outReady = 1'b0;
    bus25.inValid  = 1'b0;
    bus25.inData   = '0;
    bus25.inMode   = 1'b0;
    bus25.outReady = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("rst_out_valid32", bus32.outValid, 1'b0);
    check("rst_in_ready32",  bus32.inReady,  1'b1);
    check("rst_index32",     bus32.outIndex, 0);
    check("rst_count32",     bus32.outCount, 0);
    check("rst_data32",      bus32.outData,  0);
    check("rst_out_valid25", bus25.outValid, 1'b0);
    check("rst_in_ready25",  bus25.inReady,  1'b1);

    // Directed vectors: exact 2-cycle latency and result fields
    bus32.outReady = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      bus32.inValid = 1'b1;
      bus32.inData  = vecs[t].data;
      bus32.inMode  = vecs[t].mode;
      @(posedge clk);
      @(negedge clk);
      bus32.inValid = 1'b0;
      check("tbl_valid_early", bus32.outValid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("tbl_valid", bus32.outValid, 1'b1);
      check("tbl_found", bus32.outFound, vecs[t].found);
      check("tbl_index", bus32.outIndex, vecs[t].idx);
      check("tbl_count", bus32.outCount, vecs[t].cnt);
      check("tbl_data",  bus32.outData,  vecs[t].odata);
      check("tbl_mode",  bus32.outMode,  vecs[t].mode);
      $display("vec %0d: in=%h mode=%0d -> found=%0d idx=%0d cnt=%0d data=%h",
               t, vecs[t].data, vecs[t].mode, bus32.outFound, bus32.outIndex,
               bus32.outCount, bus32.outData);
    end

    // Backpressure: four back-to-back operands against a stalled consumer
    @(negedge clk);
    bus32.outReady = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      bus32.inValid = (acc < 4);
      bus32.inData  = bp_items[(acc < 4) ? acc : 0];
      bus32.inMode  = 1'b0;
      #1;
      check("bp_in_ready", bus32.inReady, (c < 2));
      if (c >= 2) begin
        check("bp_hold_valid", bus32.outValid, 1'b1);
        check("bp_hold_index", bus32.outIndex, 0);
      end
      if (bus32.inValid && bus32.inReady) acc++;
      @(posedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus32.outReady = 1'b1;
      bus32.inValid  = (acc < 4);
      bus32.inData   = bp_items[(acc < 4) ? acc : 0];
      #1;
      check("bp_drain_valid", bus32.outValid, 1'b1);
      check("bp_drain_index", bus32.outIndex, c);
      $display("bp drain %0d: idx=%0d", c, bus32.outIndex);
      if (bus32.inValid && bus32.inReady) acc++;
      @(posedge clk);
    end
    @(negedge clk);
    bus32.inValid = 1'b0;
    check("bp_accepted", acc, 4);
    check("bp_empty", bus32.outValid, 1'b0);

    // Reset while two transactions are stalled in flight
    bus32.outReady = 1'b0;
    bus32.inValid  = 1'b1;
    bus32.inData   = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus32.inData = 32'h20;
    @(posedge clk);
    @(negedge clk);
    bus32.inValid = 1'b0;
    #1;
    check("rst2_full", bus32.inReady, 1'b0);
    resetN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("rst2_out_valid", bus32.outValid, 1'b0);
    check("rst2_in_ready",  bus32.inReady,  1'b1);
    check("rst2_index",     bus32.outIndex, 0);
    bus32.outReady = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus32.outValid) seen++;
    end
    check("rst2_no_stale", seen, 0);
    $display("reset mid-stall: stale results seen=%0d", seen);

    // Randomized scoreboard run on the 25-bit unit
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 25; b++) begin
        s.data = 64'h1 << b;
        s.mode = m[0];
        stim_q.push_back(s);
      end
      s.data = 64'h0;
      s.mode = m[0];
      stim_q.push_back(s);
      s.data = 64'h1FF_FFFF;
      stim_q.push_back(s);
    end
    for (int k = 0; k < 10000; k++) begin
      r = 64'($urandom);
      r = r >> $urandom_range(0, 31);
      r = r << $urandom_range(0, 31);
      s.data = r & 64'h1FF_FFFF;
      s.mode = $urandom_range(0, 1) == 1;
      stim_q.push_back(s);
    end

    idx       = 0;
    cyc       = 0;
    hold_prev = 1'b0;
    held      = '0;
    while ((idx < stim_q.size() || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      act = cur25();
      if (hold_prev) begin
        check("rnd_hold_valid", bus25.outValid, 1'b1);
        check("rnd_hold_data",  act, held);
      end
      bus25.outReady = ($urandom_range(0, 3) != 0);
      if (idx < stim_q.size() && $urandom_range(0, 3) != 0) begin
        bus25.inValid = 1'b1;
        bus25.inData  = stim_q[idx].data[24:0];
        bus25.inMode  = stim_q[idx].mode;
      end else begin
        bus25.inValid = 1'b0;
      end
      #1;
      if (bus25.outValid && bus25.outReady) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL rnd_unexpected: got result %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          check("rnd_result", act, e);
        end
      end
      if (bus25.inValid && bus25.inReady) begin
        exp_q.push_back(model(stim_q[idx].data, stim_q[idx].mode, 25));
        idx++;
      end
      hold_prev = bus25.outValid && !bus25.outReady;
      held      = act;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    bus25.inValid = 1'b0;
    check("rnd_all_sent", idx, stim_q.size());
    check("rnd_all_received", exp_q.size(), 0);
    $display("random run: %0d operands in %0d cycles", idx, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
